mem_access_arbiter: RTL and testbench

Parametrised RAM-port arbiter for the DCNN IO path. It lets N_CH requesters (file loader, decompressor, CNN engine, external host, …) share one single-port RAM through a registered req/gnt handshake. Arbitration is fixed-priority or round-robin, and an optional lock holds the port for burst ownership. It sits between the requesting modules and the DMA/RAM port, replacing ad-hoc mode-select multiplexing with a fair arbiter that tracks read latency.

---
 rtl/mem_access_arbiter_pkg.sv | 39 +++
 rtl/mem_access_arbiter_if.sv | 41 ++++
 rtl/mem_access_arbiter_rr_picker.sv | 42 ++++
 rtl/mem_access_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_access_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// mem_arb_pkg: shared types, default widths and a packed-field helper for the
// RAM-port arbiter.
//   state_t   : arbiter FSM states (IDLE, ISSUE, WAIT)
//   DEF_*     : default DATA_W / ADDR_W / N_CH / RD_LAT
//   ch_field  : extracts channel 'ch' of a packed per-channel vector
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_RD_LAT = 1;

    // The helper works on a fixed maximum-width container so one function
    // serves every packed field; callers widen the vector and truncate the
    // result with explicit size casts. Fields wider than FIELD_MAX, or packed
    // vectors wider than VEC_MAX, are not supported.
    localparam int FIELD_MAX = 32;
    localparam int VEC_MAX   = 512;

    function automatic logic [FIELD_MAX-1:0] ch_field(
        input logic [VEC_MAX-1:0] vec,
        input int unsigned        ch,
        input int unsigned        width
    );
        logic [VEC_MAX-1:0]   shifted;
        logic [FIELD_MAX-1:0] mask;
        shifted = vec >> (ch * width);
        mask    = (width >= FIELD_MAX) ? '1
                : ((FIELD_MAX'(1) << width) - FIELD_MAX'(1));
        return shifted[FIELD_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_arb_if: bundles the requester handshake and the RAM port of the arbiter.
//   slave  : the arbiter side (takes requests and RAM read data, drives grants,
//            read responses, RAM strobes/address/data, busy and owner)
//   master : the requester/RAM side (mirror of slave)
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int CH_W = $clog2(N_CH);

    logic                     mode_rr;
    logic [N_CH-1:0]          req;
    logic [N_CH-1:0]          req_we;
    logic [N_CH*ADDR_W-1:0]   req_addr;
    logic [N_CH*DATA_W-1:0]   req_wdata;
    logic [N_CH-1:0]          lock;
    logic [N_CH-1:0]          gnt;
    logic [N_CH-1:0]          rvalid;
    logic [DATA_W-1:0]        rdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic                     ram_we;
    logic                     ram_re;
    logic [DATA_W-1:0]        ram_rdata;
    logic                     busy;
    logic [CH_W-1:0]          owner;

    modport slave (
        input  mode_rr, req, req_we, req_addr, req_wdata, lock, ram_rdata,
        output gnt, rvalid, rdata, ram_addr, ram_wdata, ram_we, ram_re, busy, owner
    );

    modport master (
        output mode_rr, req, req_we, req_addr, req_wdata, lock, ram_rdata,
        input  gnt, rvalid, rdata, ram_addr, ram_wdata, ram_we, ram_re, busy, owner
    );

endinterface

// File: rtl/mem_access_arbiter_rr_picker.sv
// rr_picker: combinational winner selection for the arbiter.
//   req     : request vector (already lock-masked by the caller)
//   ptr     : last-granted channel; round-robin search starts at ptr+1
//   mode_rr : 0 = lowest index wins, 1 = rotating search from ptr+1
//   win_oh  : one-hot winner, win_idx : winner index, win_any : some req set
module rr_picker #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] ptr,
    input  logic                    mode_rr,
    output logic [N_CH-1:0]         win_oh,
    output logic [$clog2(N_CH)-1:0] win_idx,
    output logic                    win_any
);
    localparam int CH_W = $clog2(N_CH);

    // Search order: position k of the scan looks at channel cand_idx[k].
    logic [CH_W-1:0] cand_idx [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand_idx[gi] = mode_rr
                ? CH_W'((32'(ptr) + 32'(gi) + 32'd1) % 32'(N_CH))
                : CH_W'(gi);
        end
    endgenerate

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_any = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!win_any && req[cand_idx[k]]) begin
                win_any              = 1'b1;
                win_idx              = cand_idx[k];
                win_oh[cand_idx[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one single-port RAM between N_CH requesters.
// One transaction is in flight at a time: IDLE picks a winner and latches its
// request, ISSUE drives the RAM for one cycle with a gnt pulse, WAIT covers
// the RAM read latency and returns rdata with an rvalid pulse.
//   clk  : rising-edge clock
//   RST  : asynchronous active-high reset
//   bus  : mem_arb_if.slave (requests, lock, mode_rr, grants, read response,
//          RAM port, busy, owner)
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic     clk,
    input  logic     RST,
    mem_arb_if.slave bus
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    state_t            state_reg;
    logic [CH_W-1:0]   owner_reg;
    logic [N_CH-1:0]   gnt_reg;
    logic [N_CH-1:0]   rvalid_reg;
    logic [N_CH-1:0]   win_oh_reg;
    logic              ram_we_reg;
    logic              ram_re_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [CNT_W-1:0]  lat_cnt_reg;

    logic [N_CH-1:0]   owner_oh;
    logic [N_CH-1:0]   cand_req;
    logic [N_CH-1:0]   win_oh;
    logic [CH_W-1:0]   win_idx;
    logic              win_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // A held lock narrows the decision to the current owner alone; other
    // channels stay pending until the owner lets go in some IDLE cycle.
    assign owner_oh = N_CH'(1) << owner_reg;
    assign cand_req = bus.lock[owner_reg] ? (bus.req & owner_oh) : bus.req;

    rr_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .req     (cand_req),
        .ptr     (owner_reg),
        .mode_rr (bus.mode_rr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    assign sel_we    = bus.req_we[win_idx];
    assign sel_addr  = ADDR_W'(ch_field(VEC_MAX'(bus.req_addr),  32'(win_idx), ADDR_W));
    assign sel_wdata = DATA_W'(ch_field(VEC_MAX'(bus.req_wdata), 32'(win_idx), DATA_W));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            owner_reg     <= CH_W'(N_CH - 1);
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            win_oh_reg    <= '0;
            ram_we_reg    <= 1'b0;
            ram_re_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            rdata_reg     <= '0;
            lat_cnt_reg   <= '0;
        end else begin
            // Strobes and pulses are single-cycle; only the branch that
            // enters ISSUE (or finishes WAIT) raises them.
            gnt_reg    <= '0;
            rvalid_reg <= '0;
            ram_we_reg <= 1'b0;
            ram_re_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        owner_reg     <= win_idx;
                        win_oh_reg    <= win_oh;
                        gnt_reg       <= win_oh;
                        ram_addr_reg  <= sel_addr;
                        ram_wdata_reg <= sel_wdata;
                        ram_we_reg    <= sel_we;
                        ram_re_reg    <= ~sel_we;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt_reg <= '0;
                    state_reg   <= ram_we_reg ? IDLE : WAIT;
                end
                WAIT: begin
                    if (lat_cnt_reg == CNT_W'(RD_LAT - 1)) begin
                        rdata_reg  <= bus.ram_rdata;
                        rvalid_reg <= win_oh_reg;
                        state_reg  <= IDLE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.rvalid    = rvalid_reg;
    assign bus.rdata     = rdata_reg;
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign bus.ram_we    = ram_we_reg;
    assign bus.ram_re    = ram_re_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.owner     = owner_reg;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter (N_CH=4, ADDR_W=16, DATA_W=8, RD_LAT=2).
// Stimulus loads per-channel request queues and pushes expected grants and
// read responses; a monitor pops and compares whenever gnt or rvalid shows.
module tb_mem_access_arbiter;
    import mem_arb_pkg::*;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    typedef struct { bit we; logic [15:0] addr; logic [7:0] wdata; bit lk; } op_t;
    typedef struct { int ch; bit we; logic [15:0] addr; logic [7:0] wdata; int gap; } gexp_t;
    typedef struct { int ch; logic [7:0] data; } rexp_t;

    logic clk = 1'b0;
    logic rst;

    mem_arb_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_access_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_CH   (N_CH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    op_t        chq [N_CH][$];
    gexp_t      gq[$];
    rexp_t      rq[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;
    int         last_gnt_cyc = 0;
    int         gnt_cyc [N_CH];
    logic [7:0] mem [0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(bit we, logic [15:0] a, logic [7:0] d, bit lk);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d; o.lk = lk;
        return o;
    endfunction

    function automatic gexp_t mk_g(int ch, bit we, logic [15:0] a, logic [7:0] d, int gap);
        gexp_t g;
        g.ch = ch; g.we = we; g.addr = a; g.wdata = d; g.gap = gap;
        return g;
    endfunction

    function automatic rexp_t mk_r(int ch, logic [7:0] d);
        rexp_t r;
        r.ch = ch; r.data = d;
        return r;
    endfunction

    task automatic drive_reqs();
        logic [N_CH-1:0]        r, w, l;
        logic [N_CH*ADDR_W-1:0] a;
        logic [N_CH*DATA_W-1:0] d;
        r = '0; w = '0; l = '0; a = '0; d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (chq[c].size() > 0) begin
                r[c] = 1'b1;
                w[c] = chq[c][0].we;
                l[c] = chq[c][0].lk;
                a[c*ADDR_W +: ADDR_W] = chq[c][0].addr;
                d[c*DATA_W +: DATA_W] = chq[c][0].wdata;
            end
        end
        bus.req = r; bus.req_we = w; bus.lock = l;
        bus.req_addr = a; bus.req_wdata = d;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"},       32'(bus.gnt),       32'd0);
        check({tag, "_rvalid"},    32'(bus.rvalid),    32'd0);
        check({tag, "_ram_we"},    32'(bus.ram_we),    32'd0);
        check({tag, "_ram_re"},    32'(bus.ram_re),    32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_rdata"},     32'(bus.rdata),     32'd0);
        check({tag, "_ram_addr"},  32'(bus.ram_addr),  32'd0);
        check({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
        check({tag, "_owner"},     32'(bus.owner),     32'd3);
    endtask

    task automatic wait_done(input string name);
        int t;
        int pending;
        t = 0;
        while ((gq.size() + rq.size() + chq[0].size() + chq[1].size() + chq[2].size()
                + chq[3].size()) != 0 || bus.busy) begin
            if (t >= 300) break;
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        pending = gq.size() + rq.size();
        check({name, "_drained"}, 32'(pending), 32'd0);
        gq.delete(); rq.delete();
        for (int c = 0; c < N_CH; c++) chq[c].delete();
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // requester driver: retire the granted op, present each channel's next op
    initial begin
        drive_reqs();
        forever begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++)
                if (!rst && bus.gnt[c] && chq[c].size() > 0) void'(chq[c].pop_front());
            drive_reqs();
        end
    end

    // RAM model: data is present only in the cycle where it must be sampled
    initial begin
        int         rd_cnt;
        logic [7:0] rd_data;
        rd_cnt = 0;
        rd_data = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0040] = 8'hA5;
        mem[16'h0010] = 8'h5A;
        bus.ram_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            if (rd_cnt > 0) begin
                rd_cnt--;
                bus.ram_rdata = (rd_cnt == 0) ? rd_data : 8'hEE;
            end else begin
                bus.ram_rdata = 8'hEE;
            end
            if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
            if (bus.ram_re) begin
                rd_cnt = RD_LAT;
                rd_data = mem[bus.ram_addr];
            end
        end
    end

    // monitor / scoreboard
    initial begin
        gexp_t ge;
        rexp_t re;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.gnt != '0) begin
                    if (gq.size() == 0) begin
                        check("unexpected_gnt", 32'(bus.gnt), 32'd0);
                    end else begin
                        ge = gq.pop_front();
                        check("gnt_vec",  32'(bus.gnt),      32'(1 << ge.ch));
                        check("ram_we",   32'(bus.ram_we),   32'(ge.we));
                        check("ram_re",   32'(bus.ram_re),   32'(!ge.we));
                        check("ram_addr", 32'(bus.ram_addr), 32'(ge.addr));
                        check("owner",    32'(bus.owner),    32'(ge.ch));
                        check("busy",     32'(bus.busy),     32'd1);
                        if (ge.we) check("ram_wdata", 32'(bus.ram_wdata), 32'(ge.wdata));
                        if (ge.gap != 0) check("gnt_gap", 32'(cyc - last_gnt_cyc), 32'(ge.gap));
                        last_gnt_cyc = cyc;
                        gnt_cyc[ge.ch] = cyc;
                    end
                end else if (bus.ram_we || bus.ram_re) begin
                    check("strobe_without_gnt", 32'({bus.ram_we, bus.ram_re}), 32'd0);
                end
                if (bus.rvalid != '0) begin
                    if (rq.size() == 0) begin
                        check("unexpected_rvalid", 32'(bus.rvalid), 32'd0);
                    end else begin
                        re = rq.pop_front();
                        check("rvalid_vec", 32'(bus.rvalid), 32'(1 << re.ch));
                        check("rdata",      32'(bus.rdata),  32'(re.data));
                        check("rd_latency", 32'(cyc - gnt_cyc[re.ch]), 32'(RD_LAT + 1));
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        int t;
        rst = 1'b1;
        bus.mode_rr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // lock burst: owner after reset is ch3, lock holds the port for 3 writes
        chq[3].push_back(mk(1'b1, 16'h0300, 8'h31, 1'b1));
        chq[3].push_back(mk(1'b1, 16'h0301, 8'h32, 1'b1));
        chq[3].push_back(mk(1'b1, 16'h0302, 8'h33, 1'b1));
        chq[0].push_back(mk(1'b1, 16'h0000, 8'h01, 1'b0));
        gq.push_back(mk_g(3, 1'b1, 16'h0300, 8'h31, 0));
        gq.push_back(mk_g(3, 1'b1, 16'h0301, 8'h32, 2));
        gq.push_back(mk_g(3, 1'b1, 16'h0302, 8'h33, 2));
        gq.push_back(mk_g(0, 1'b1, 16'h0000, 8'h01, 2));
        wait_done("lock");

        // single read from ch2, RAM holds 0xA5 at 0x0040
        chq[2].push_back(mk(1'b0, 16'h0040, 8'h00, 1'b0));
        gq.push_back(mk_g(2, 1'b0, 16'h0040, 8'h00, 0));
        rq.push_back(mk_r(2, 8'hA5));
        wait_done("single_read");

        // fixed priority, req=1110, all writes
        chq[1].push_back(mk(1'b1, 16'h0101, 8'h11, 1'b0));
        chq[2].push_back(mk(1'b1, 16'h0202, 8'h22, 1'b0));
        chq[3].push_back(mk(1'b1, 16'h0303, 8'h33, 1'b0));
        gq.push_back(mk_g(1, 1'b1, 16'h0101, 8'h11, 0));
        gq.push_back(mk_g(2, 1'b1, 16'h0202, 8'h22, 2));
        gq.push_back(mk_g(3, 1'b1, 16'h0303, 8'h33, 2));
        wait_done("fixed");

        // round-robin, all channels continuously requesting (owner is ch3)
        bus.mode_rr = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N_CH; c++) begin
                chq[c].push_back(mk(1'b1, 16'h1000 + 16'(c*16 + k), 8'h40 + 8'(c*4 + k), 1'b0));
                gq.push_back(mk_g(c, 1'b1, 16'h1000 + 16'(c*16 + k), 8'h40 + 8'(c*4 + k),
                                  (k == 0 && c == 0) ? 0 : 2));
            end
        wait_done("round_robin");
        bus.mode_rr = 1'b0;

        // write to boundary address, then read it back
        chq[1].push_back(mk(1'b1, 16'hFFFF, 8'h3C, 1'b0));
        gq.push_back(mk_g(1, 1'b1, 16'hFFFF, 8'h3C, 0));
        wait_done("write_path");
        check("ram_addr_hold", 32'(bus.ram_addr), 32'h0000FFFF);
        chq[1].push_back(mk(1'b0, 16'hFFFF, 8'h00, 1'b0));
        gq.push_back(mk_g(1, 1'b0, 16'hFFFF, 8'h00, 0));
        rq.push_back(mk_r(1, 8'h3C));
        wait_done("readback");

        // reset during WAIT: the read must never produce rvalid
        chq[2].push_back(mk(1'b0, 16'h0010, 8'h00, 1'b0));
        gq.push_back(mk_g(2, 1'b0, 16'h0010, 8'h00, 0));
        t = 0;
        while (bus.gnt == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_gnt_seen", 32'(bus.gnt != '0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        wait_done("mid_reset_quiet");

        // fresh ch0 read after the reset
        chq[0].push_back(mk(1'b0, 16'h0040, 8'h00, 1'b0));
        gq.push_back(mk_g(0, 1'b0, 16'h0040, 8'h00, 0));
        rq.push_back(mk_r(0, 8'hA5));
        wait_done("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
